// File: rtl/cavlc_pkg.sv
// cavlc_pkg: shared widths and types for the CAVLC bitstream front end.
package cavlc_pkg;
  localparam int WORD_W = 32;
  localparam int WIN_W  = 16;
  localparam int BUF_W  = 64;
  typedef logic [4:0] shamt_t;
  typedef logic [6:0] bitcnt_t;
endpackage

// File: rtl/cavlc_lshift.sv
// cavlc_lshift: combinational logical left barrel shifter, one mux stage per shamt bit.
module cavlc_lshift
  import cavlc_pkg::*;
(
  input  logic [BUF_W-1:0] data,
  input  logic [5:0]       shamt,
  output logic [BUF_W-1:0] result
);
  logic [BUF_W-1:0] stage [7];
  assign stage[0] = data;
  for (genvar i = 0; i < 6; i++) begin : g_stage
    assign stage[i+1] = shamt[i] ? (stage[i] << (1 << i)) : stage[i];
  end
  assign result = stage[6];
endmodule

// File: rtl/cavlc_bit_buffer.sv
// cavlc_bit_buffer: 64-bit MSB-aligned bit store feeding a 16-bit look-ahead window
// to the coefficient-token decoder, with word loads and 0..16-bit consumes per cycle.
module cavlc_bit_buffer
  import cavlc_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic [WORD_W-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [WIN_W-1:0]  Window,
  output logic              WindowValid,
  input  logic              ShiftEn,
  input  shamt_t            NumShift,
  output logic [CNT_W-1:0]  BitsConsumed,
  output logic              ShiftErr
);
  logic [BUF_W-1:0] bitBuf, shifted, aligned;
  bitcnt_t          bitCnt, remain;
  logic [CNT_W-1:0] consumed;
  logic             err, load, badShift;
  shamt_t           shamt;
  assign WindowValid  = bitCnt >= 7'd16;
  assign InReady      = bitCnt <= 7'd32;
  assign Window       = bitBuf[BUF_W-1 -: WIN_W];
  assign BitsConsumed = consumed;
  assign ShiftErr     = err;
  always_comb begin
    shamt    = (ShiftEn && WindowValid) ? ((NumShift > 5'd16) ? 5'd16 : NumShift) : 5'd0;
    badShift = ShiftEn && (!WindowValid || NumShift > 5'd16);
    load     = InValid && InReady;
    remain   = bitCnt - {2'b00, shamt};
  end
  cavlc_lshift uConsume (
    .data  (bitBuf),
    .shamt ({1'b0, shamt}),
    .result(shifted)
  );
  // Word sits in the low half and is lifted so its MSB lands just after the remainder.
  cavlc_lshift uAlign (
    .data  ({{(BUF_W-WORD_W){1'b0}}, InData}),
    .shamt (6'(7'd32 - remain)),
    .result(aligned)
  );
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bitBuf   <= '0;
      bitCnt   <= '0;
      consumed <= '0;
      err      <= 1'b0;
    end else if (Flush) begin
      bitBuf <= '0;
      bitCnt <= '0;
      err    <= 1'b0;
    end else begin
      bitBuf   <= shifted | (load ? aligned : '0);
      bitCnt   <= remain + (load ? 7'd32 : 7'd0);
      consumed <= consumed + CNT_W'(shamt);
      if (badShift) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cavlc_bit_buffer.sv
// tb_cavlc_bit_buffer: directed vector table plus bit-queue reference model run.
module tb_cavlc_bit_buffer;
  logic        Clk = 1'b0, Reset = 1'b1, Flush = 1'b0, InValid = 1'b0, ShiftEn = 1'b0;
  logic [31:0] InData = '0;
  logic [4:0]  NumShift = '0;
  logic        InReady, WindowValid, ShiftErr;
  logic [15:0] Window;
  logic [23:0] BitsConsumed;
  int errors = 0, checks = 0;

  cavlc_bit_buffer dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InData(InData), .InValid(InValid),
    .InReady(InReady), .Window(Window), .WindowValid(WindowValid), .ShiftEn(ShiftEn),
    .NumShift(NumShift), .BitsConsumed(BitsConsumed), .ShiftErr(ShiftErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        fl, iv;
    logic [31:0] d;
    logic        se;
    logic [4:0]  ns;
    logic [15:0] win;
    logic        wv, rdy, err;
    logic [23:0] cons;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic fl, iv, input logic [31:0] d, input logic se,
                     input logic [4:0] ns, input logic [15:0] win,
                     input logic wv, rdy, err, input logic [23:0] cons);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.se = se; v.ns = ns;
    v.win = win; v.wv = wv; v.rdy = rdy; v.err = err; v.cons = cons;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string nm, input logic [15:0] win, input logic wv, rdy, err,
                         input logic [23:0] cons);
    chk({nm, " Window"}, 64'(Window), 64'(win));
    chk({nm, " WindowValid"}, 64'(WindowValid), 64'(wv));
    chk({nm, " InReady"}, 64'(InReady), 64'(rdy));
    chk({nm, " ShiftErr"}, 64'(ShiftErr), 64'(err));
    chk({nm, " BitsConsumed"}, 64'(BitsConsumed), 64'(cons));
  endtask

  bit          q[$];
  logic [23:0] mCons;
  logic [31:0] pend;
  logic [15:0] mWin;
  int          s;
  bit          l;

  initial begin
    //   fl iv data          se ns   win     wv rdy err cons
    add(0, 1, 32'hA5A50000, 0, 0,  16'hA5A5, 1, 1, 0, 0);
    add(1, 0, 32'h0,        0, 0,  16'h0000, 0, 1, 0, 0);
    add(0, 1, 32'h80000001, 0, 0,  16'h8000, 1, 1, 0, 0);
    add(0, 1, 32'hFFFFFFFF, 0, 0,  16'h8000, 1, 0, 0, 0);
    add(0, 0, 32'h0,        1, 1,  16'h0000, 1, 0, 0, 1);
    add(0, 0, 32'h0,        1, 15, 16'h0001, 1, 0, 0, 16);
    add(0, 0, 32'h0,        1, 16, 16'hFFFF, 1, 1, 0, 32);
    add(0, 0, 32'h0,        1, 16, 16'hFFFF, 1, 1, 0, 48);
    add(1, 0, 32'h0,        0, 0,  16'h0000, 0, 1, 0, 48);
    add(0, 1, 32'h12345678, 0, 0,  16'h1234, 1, 1, 0, 48);
    add(0, 1, 32'h9ABCDEF0, 0, 0,  16'h1234, 1, 0, 0, 48);
    add(0, 1, 32'hDEADBEEF, 0, 0,  16'h1234, 1, 0, 0, 48);
    add(0, 1, 32'hCAFEF00D, 1, 16, 16'h5678, 1, 0, 0, 64);
    add(0, 1, 32'h0BADF00D, 1, 16, 16'h9ABC, 1, 1, 0, 80);
    add(0, 1, 32'h0BADF00D, 0, 0,  16'h9ABC, 1, 0, 0, 80);
    add(0, 0, 32'h0,        1, 16, 16'hDEF0, 1, 0, 0, 96);
    add(0, 0, 32'h0,        1, 16, 16'h0BAD, 1, 1, 0, 112);
    add(0, 0, 32'h0,        1, 16, 16'hF00D, 1, 1, 0, 128);
    add(1, 0, 32'h0,        0, 0,  16'h0000, 0, 1, 0, 128);
    add(0, 1, 32'h13579BDF, 0, 0,  16'h1357, 1, 1, 0, 128);
    add(0, 0, 32'h0,        1, 12, 16'h79BD, 1, 1, 0, 140);
    add(0, 1, 32'hF0F0F0F0, 1, 3,  16'hCDEF, 1, 0, 0, 143);
    add(0, 0, 32'h0,        1, 16, 16'hF878, 1, 0, 0, 159);
    add(1, 0, 32'h0,        0, 0,  16'h0000, 0, 1, 0, 159);
    add(0, 1, 32'h0000FFFF, 0, 0,  16'h0000, 1, 1, 0, 159);
    add(0, 0, 32'h0,        1, 20, 16'hFFFF, 1, 1, 1, 175);
    add(1, 0, 32'h0,        0, 0,  16'h0000, 0, 1, 0, 175);
    add(0, 1, 32'h000000AB, 0, 0,  16'h0000, 1, 1, 0, 175);
    add(0, 0, 32'h0,        1, 16, 16'h00AB, 1, 1, 0, 191);
    add(0, 0, 32'h0,        1, 8,  16'hAB00, 0, 1, 0, 199);
    add(0, 0, 32'h0,        1, 4,  16'hAB00, 0, 1, 1, 199);
    add(1, 1, 32'hFFFFFFFF, 1, 4,  16'h0000, 0, 1, 0, 199);
    add(0, 0, 32'h0,        0, 0,  16'h0000, 0, 1, 0, 199);

    #12 Reset = 1'b0;
    @(posedge Clk); #1;
    chk_all("reset", 16'h0, 1'b0, 1'b1, 1'b0, 24'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      Flush = vecs[i].fl; InValid = vecs[i].iv; InData = vecs[i].d;
      ShiftEn = vecs[i].se; NumShift = vecs[i].ns;
      @(posedge Clk); #1;
      chk_all($sformatf("v%0d", i), vecs[i].win, vecs[i].wv, vecs[i].rdy, vecs[i].err,
              vecs[i].cons);
    end

    Flush = 1'b1; InValid = 1'b0; ShiftEn = 1'b0;
    @(posedge Clk); #1;
    Flush = 1'b0;
    mCons = BitsConsumed == 24'd199 ? 24'd199 : 24'd199;
    pend = $urandom;
    for (int c = 0; c < 3000; c++) begin
      mWin = '0;
      for (int b = 0; b < 16 && b < q.size(); b++) mWin[15-b] = q[b];
      chk("rnd WindowValid", 64'(WindowValid), 64'(q.size() >= 16));
      chk("rnd InReady", 64'(InReady), 64'(q.size() <= 32));
      chk("rnd BitsConsumed", 64'(BitsConsumed), 64'(mCons));
      chk("rnd ShiftErr", 64'(ShiftErr), 64'd0);
      if (q.size() >= 16) chk("rnd Window", 64'(Window), 64'(mWin));
      InValid  = $urandom_range(0, 3) != 0;
      InData   = pend;
      ShiftEn  = q.size() >= 16 && $urandom_range(0, 3) != 0;
      NumShift = 5'($urandom_range(0, 16));
      s = ShiftEn ? int'(NumShift) : 0;
      l = InValid && q.size() <= 32;
      @(posedge Clk); #1;
      for (int b = 0; b < s; b++) void'(q.pop_front());
      mCons += 24'(s);
      if (l) begin
        for (int b = 31; b >= 0; b--) q.push_back(pend[b]);
        pend = $urandom;
      end
    end

    InValid = 1'b0; ShiftEn = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk_all("async reset", 16'h0, 1'b0, 1'b1, 1'b0, 24'd0);
    #3 Reset = 1'b0;
    @(posedge Clk); #1;
    chk_all("post reset", 16'h0, 1'b0, 1'b1, 1'b0, 24'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
